// File: rtl/pipe_skid_chain.sv
// Valid/ready register chain: STAGES stages of main+skid registers, registered in_ready, flush.
// Optional occupancy counter output `occ` when PIPE_OCC_COUNT_EN is defined.
module pipe_skid_chain #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PIPE_OCC_COUNT_EN
   ,
   output logic [$clog2(2*STAGES+1)-1:0] occ
`endif
);

   if (STAGES < 1) begin : g_bad_stages
      $error("pipe_skid_chain: STAGES must be >= 1");
   end
   if (WIDTH < 1) begin : g_bad_width
      $error("pipe_skid_chain: WIDTH must be >= 1");
   end

   logic [STAGES-1:0] mv_q, mv_d, sv_q, sv_d;
   logic [WIDTH-1:0]  md_q [STAGES];
   logic [WIDTH-1:0]  md_d [STAGES];
   logic [WIDTH-1:0]  sd_q [STAGES];
   logic [WIDTH-1:0]  sd_d [STAGES];

   logic [STAGES-1:0] up_valid, down_ready, acc, pop;
   logic [WIDTH-1:0]  up_data [STAGES];

   // A stage is ready whenever its skid is empty, so readiness is always a flop output.
   for (genvar k = 0; k < STAGES; k++) begin : g_link
      if (k == 0) begin : g_head
         assign up_valid[k] = in_valid;
         assign up_data[k]  = in_data;
      end else begin : g_mid
         assign up_valid[k] = mv_q[k-1];
         assign up_data[k]  = md_q[k-1];
      end
      if (k == STAGES-1) begin : g_tail
         assign down_ready[k] = out_ready;
      end else begin : g_inner
         assign down_ready[k] = ~sv_q[k+1];
      end
      assign acc[k] = up_valid[k] & ~sv_q[k];
      assign pop[k] = mv_q[k] & down_ready[k];
   end

   always_comb begin
      mv_d = mv_q;
      sv_d = sv_q;
      md_d = md_q;
      sd_d = sd_q;
      if (flush) begin
         mv_d = '0;
         sv_d = '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (!mv_q[k] || pop[k]) begin
               // Main is free this edge: refill from skid first to keep FIFO order.
               sv_d[k] = 1'b0;
               if (sv_q[k]) begin
                  mv_d[k] = 1'b1;
                  md_d[k] = sd_q[k];
               end else if (acc[k]) begin
                  mv_d[k] = 1'b1;
                  md_d[k] = up_data[k];
               end else begin
                  mv_d[k] = 1'b0;
               end
            end else if (acc[k]) begin
               sv_d[k] = 1'b1;
               sd_d[k] = up_data[k];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mv_q <= '0;
         sv_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            md_q[k] <= '0;
            sd_q[k] <= '0;
         end
      end else begin
         mv_q <= mv_d;
         sv_q <= sv_d;
         for (int k = 0; k < STAGES; k++) begin
            md_q[k] <= md_d[k];
            sd_q[k] <= sd_d[k];
         end
      end
   end

   assign in_ready  = ~sv_q[0];
   assign out_valid = mv_q[STAGES-1];
   assign out_data  = md_q[STAGES-1];

`ifdef PIPE_OCC_COUNT_EN
   localparam int OCC_W = $clog2(2*STAGES+1);
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             in_hs, out_hs;

   assign in_hs  = in_valid & in_ready;
   assign out_hs = out_valid & out_ready;

   always_comb begin
      occ_d = occ_q;
      if (flush) begin
         occ_d = '0;
      end else if (in_hs && !out_hs) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (out_hs && !in_hs) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occ = occ_q;
`endif

endmodule
